byte_lane_packer: RTL
=====================

Name: byte_lane_packer

Overview:
- Parametrised successor to the single-byte header-import modules. Accepts a stream of byte_t beats and packs LANES bytes into one word, with valid/ready handshakes on both sides.
- An early in_last closes a partial word, flagged through a per-lane keep mask.
- Sits between byte-serial front ends and word-wide datapaths.
- Package types reach the module through a header-level wildcard import placed before the port list.

Parameters:
- LANES, 4, bytes per output word; legal range 2..16.
- CNT_W, $clog2(LANES+1), width of the internal byte counter; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  byte_t (8)  input byte.
- in_last  input  1  marks the final byte of a packet.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  LANES*WIDTH  packed word; lane 0 is bits [WIDTH-1:0].
- out_keep  output  LANES  bit i set means lane i carries data.
- out_last  output  1  word contains the packet's final byte.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - Accumulator and counter cleared; state=COLLECT.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after release.
  - Reset mid-packet discards all partial bytes, with no flush word.
- Definitions:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
  - slot_free = !out_valid || out_fire.
- State COLLECT: in_ready=1.
  - On in_fire, byte goes to lane cnt and keep bit cnt is set.
  - If this byte completes the word (cnt==LANES-1 or in_last) and slot_free: output registers load the word, keep and last next edge; accumulator clears; cnt returns to 0.
  - If it completes the word and !slot_free: state goes to HOLD and the word is held in the accumulator.
  - Otherwise cnt increments.
- State HOLD: in_ready=0.
  - When slot_free: load the output from the accumulator, clear it, return to COLLECT.
- Latency and throughput:
  - One cycle from the completing in_fire to out_valid.
  - Sustained throughput is 1 byte/cycle with out_ready held high.
  - No bubble between consecutive words.
- Output stability: out_data, out_keep and out_last stay stable while out_valid && !out_ready.
- Unused lanes of a partial word drive 0 in out_data.
- out_keep is always a contiguous run of ones starting at bit 0.
- in_last on the LANES-th byte gives a full word with out_keep all ones and out_last=1.
- A single-byte packet (in_last on the first byte) gives out_keep=1 and out_last=1.
- Width rules:
  - Counter compares at CNT_W bits.
  - Lane index is cnt, truncated to $clog2(LANES) bits.
  - No arithmetic on data bytes.
- in_data and in_last are ignored when !in_fire.

Decomposition:
- Package lane_pkg:
  - byte_t (logic [7:0]).
  - parameter int WIDTH = 8.
  - typedef enum logic {COLLECT, HOLD} pack_state_t.
- The module imports lane_pkg::* in its header, between the module name and the port list, so byte_t is usable in port declarations.
- One natural sub-module: lane_out_reg, the output register slice holding data, keep and last with the valid/ready stall rule.
- Collector FSM and accumulator stay in the top module.

Test Plan (LANES=4):
- 4 beats 0x11,0x22,0x33,0x44, in_last on the 4th, out_ready=1 -> one cycle after the 4th beat: out_data=0x44332211, out_keep=4'b1111, out_last=1.
- 3 beats 0xA1,0xB2,0xC3, in_last on the 3rd -> out_data=0x00C3B2A1, out_keep=4'b0111, out_last=1.
- 8 back-to-back beats 0x01..0x08, no in_last, out_ready=1 -> in_ready stays 1 throughout; words 0x04030201 then 0x08070605, each with out_last=0 and out_keep=4'b1111.
- out_ready=0 while 8 beats are offered -> the first word is held stable, HOLD is entered after the 8th byte, and in_ready=0. Raising out_ready drains 0x04030201 then 0x08070605 in consecutive cycles, then in_ready=1.
- Single beat 0x5A with in_last -> out_data=0x0000005A, out_keep=4'b0001, out_last=1.
- 2 beats 0x10,0x20 then rst_n pulsed low for 1 cycle mid-clock -> all outputs 0 immediately. Next packet 0x30..0x33 with in_last gives 0x33323130 with no trace of 0x10 or 0x20.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared types for the byte-to-word lane packer.
package lane_pkg;
  typedef logic [7:0] byte_t;
  parameter int WIDTH = 8;
  typedef enum logic {COLLECT, HOLD} pack_state_t;
endpackage

// File: rtl/lane_out_reg.sv
// Output register slice: loads a packed word and holds it until downstream accepts.
module lane_out_reg
  import lane_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [LANES*WIDTH-1:0] load_data,
  input  logic [LANES-1:0]       load_keep,
  input  logic                   load_last,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_keep  <= load_keep;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      // payload is left in place; only valid drops
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_lane_packer.sv
// Packs a byte stream into LANES-byte words with keep mask and last flag.
// state   | meaning
// COLLECT | accepting bytes into the accumulator
// HOLD    | completed word waiting for the output slot; input stalled
module byte_lane_packer
  import lane_pkg::*;
#(
  parameter int  LANES = 4,
  localparam int CNT_W = $clog2(LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  byte_t                  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_last
);

  localparam int IDX_W = $clog2(LANES);

  pack_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [LANES*WIDTH-1:0] acc_data_q;
  logic [LANES-1:0]       acc_keep_q;
  logic                   acc_last_q;
  logic                   ready_en_q;

  logic                   in_fire, out_fire, slot_free, word_done, load;
  logic [IDX_W-1:0]       lane_idx;
  logic [LANES*WIDTH-1:0] word_data, load_data;
  logic [LANES-1:0]       word_keep, load_keep;
  logic                   load_last;

  assign in_ready  = ready_en_q && (state_q == COLLECT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign slot_free = !out_valid || out_fire;
  assign lane_idx  = cnt_q[IDX_W-1:0];
  assign word_done = in_fire && ((cnt_q == CNT_W'(LANES - 1)) || in_last);

  // accumulator contents with the incoming byte merged into lane cnt
  always_comb begin
    word_data = acc_data_q;
    word_keep = acc_keep_q;
    for (int i = 0; i < LANES; i++) begin
      if (lane_idx == IDX_W'(i)) begin
        word_data[i*WIDTH +: WIDTH] = in_data;
        word_keep[i]                = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_data = word_data;
    load_keep = word_keep;
    load_last = in_last;
    case (state_q)
      COLLECT: begin
        if (word_done) begin
          if (slot_free) load = 1'b1;
          else           state_d = HOLD;
        end
      end
      HOLD: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = acc_data_q;
          load_keep = acc_keep_q;
          load_last = acc_last_q;
          state_d   = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      acc_last_q <= 1'b0;
    end else if (state_q == COLLECT) begin
      if (in_fire) begin
        if (word_done) begin
          cnt_q <= '0;
          if (slot_free) begin
            acc_data_q <= '0;
            acc_keep_q <= '0;
            acc_last_q <= 1'b0;
          end else begin
            acc_data_q <= word_data;
            acc_keep_q <= word_keep;
            acc_last_q <= in_last;
          end
        end else begin
          acc_data_q <= word_data;
          acc_keep_q <= word_keep;
          cnt_q      <= cnt_q + CNT_W'(1);
        end
      end
    end else if (slot_free) begin
      acc_data_q <= '0;
      acc_keep_q <= '0;
      acc_last_q <= 1'b0;
    end
  end

  lane_out_reg #(.LANES(LANES)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .load_last (load_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

endmodule
